// File: rtl/hex_display_bank.sv
// Avalon-MM controller for up to eight seven-segment digits. Each digit shows either a
// raw or hex-decoded pattern, with per-digit blink, global PWM brightness and global blank.
module hex_display_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] hex_out
);

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0]   r_mode;
  logic [NUM_DIGITS-1:0]   r_blink;
  logic [PWM_BITS-1:0]     r_bright;
  logic                    r_blank;
  logic [CNT_W-1:0]        r_blink_cnt;
  logic                    r_phase;
  logic [PWM_BITS-1:0]     r_pwm_cnt;
  logic [8*NUM_DIGITS-1:0] w_digit_flat;
  logic                    w_wr;
  logic                    w_restart;
  logic                    w_lit;

  assign w_wr      = chipselect && !write_n;
  assign w_restart = w_wr && (address == 4'd11) && writedata[1];
  assign w_lit     = (r_bright == {PWM_BITS{1'b1}}) || (r_pwm_cnt < r_bright);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode      <= '0;
      r_blink     <= '0;
      r_bright    <= '1;
      r_blank     <= 1'b1;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_pwm_cnt   <= '0;
    end else begin
      if (w_wr && address == 4'd8)  r_mode   <= writedata[NUM_DIGITS-1:0];
      if (w_wr && address == 4'd9)  r_blink  <= writedata[NUM_DIGITS-1:0];
      if (w_wr && address == 4'd10) r_bright <= writedata[PWM_BITS-1:0];
      if (w_wr && address == 4'd11) r_blank  <= writedata[0];
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      // RESTART takes priority over a wrap landing on the same edge
      if (w_restart) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
      end else if (r_blink_cnt == CNT_MAX) begin
        r_blink_cnt <= '0;
        r_phase     <= !r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [7:0] r_digit;
      logic [7:0] r_hex;
      logic [7:0] w_pattern;
      logic       w_dark;

      assign w_pattern = r_mode[gi] ? {~r_digit[7], seg7(r_digit[3:0])} : r_digit;
      assign w_dark    = r_blank || (r_blink[gi] && !r_phase) || !w_lit;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_digit <= 8'h00;
          r_hex   <= 8'hFF;
        end else begin
          if (w_wr && address == 4'(gi)) r_digit <= writedata[7:0];
          r_hex <= w_dark ? 8'hFF : w_pattern;
        end
      end

      assign w_digit_flat[8*gi +: 8] = r_digit;
      assign hex_out[8*gi +: 8]      = r_hex;
    end
  endgenerate

  always_comb begin
    readdata = '0;
    case (address)
      4'd8:  readdata[NUM_DIGITS-1:0] = r_mode;
      4'd9:  readdata[NUM_DIGITS-1:0] = r_blink;
      4'd10: readdata[PWM_BITS-1:0]   = r_bright;
      4'd11: begin
        readdata[0] = r_blank;
        readdata[8] = r_phase;
      end
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (int'(address) == i) readdata[7:0] = w_digit_flat[8*i +: 8];
        end
      end
    endcase
  end

endmodule
